joypad_port_arbiter: RTL

Assigns up to four Analogue Pocket controller slots to the two MSX joystick ports. Hot-plug is handled with a debounced presence filter and a scan/lock state machine. The block sits between the per-slot `joypad` synchronisers and the PSG port A/B input mux. Its outputs are active-low MSX joystick words, with SOCD cleaning and autofire applied.

---
 rtl/joypad_port_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/joypad_port_arbiter.sv
// Maps up to four hot-pluggable controller slots onto the two MSX joystick ports,
// with debounced presence, a scan/lock assignment FSM, SOCD cleaning and autofire.
module joypad_port_arbiter #(
    parameter logic [15:0] HOTPLUG_HOLD = 16'd1024,
    parameter logic [23:0] AUTOFIRE_DIV = 24'd1_000_000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [15:0] slot_type,
    input  logic [63:0] slot_keys,
    input  logic        reassign,
    input  logic        autofire_en,
    output logic [5:0]  msx_joy_a,
    output logic [5:0]  msx_joy_b,
    output logic [2:0]  port_slot_a,
    output logic [2:0]  port_slot_b,
    output logic        locked
);

    localparam logic [2:0]  NONE      = 3'd4;
    localparam logic [15:0] HOLD_LAST = HOTPLUG_HOLD - 16'd1;
    localparam logic [23:0] AF_LAST   = AUTOFIRE_DIV - 24'd1;

    typedef enum logic {StScan, StLock} state_e;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  port_a_q, port_a_d;
    logic [2:0]  port_b_q, port_b_d;
    logic [3:0]  present_q;
    logic [15:0] hold_cnt_q [4];
    logic [3:0]  raw;
    logic [3:0]  assigned;
    logic        a_lost, b_lost;
    logic [23:0] af_cnt_q;
    logic        af_phase_q;
    logic [5:0]  joy_a_q, joy_b_q;

    always_comb begin
        raw      = '0;
        assigned = '0;
        for (int n = 0; n < 4; n++) begin
            raw[n]      = |slot_type[4*n +: 4];
            assigned[n] = (port_a_q == 3'(n)) || (port_b_q == 3'(n));
        end
    end

    // Presence only flips after raw has disagreed for HOTPLUG_HOLD consecutive cycles.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            present_q <= '0;
            for (int n = 0; n < 4; n++) hold_cnt_q[n] <= '0;
        end else begin
            for (int n = 0; n < 4; n++) begin
                if (raw[n] == present_q[n]) begin
                    hold_cnt_q[n] <= '0;
                end else if (hold_cnt_q[n] == HOLD_LAST) begin
                    present_q[n]  <= raw[n];
                    hold_cnt_q[n] <= '0;
                end else begin
                    hold_cnt_q[n] <= hold_cnt_q[n] + 16'd1;
                end
            end
        end
    end

    assign a_lost = (port_a_q != NONE) && !present_q[port_a_q[1:0]];
    assign b_lost = (port_b_q != NONE) && !present_q[port_b_q[1:0]];

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        port_a_d = port_a_q;
        port_b_d = port_b_q;
        unique case (state_q)
            StScan: begin
                if (reassign) begin
                    port_a_d = NONE;
                    port_b_d = NONE;
                    idx_d    = 2'd0;
                end else begin
                    if (present_q[idx_q] && !assigned[idx_q]) begin
                        if (port_a_q == NONE)      port_a_d = {1'b0, idx_q};
                        else if (port_b_q == NONE) port_b_d = {1'b0, idx_q};
                    end
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) state_d = StLock;
                end
            end
            StLock: begin
                idx_d = 2'd0;
                if (reassign) begin
                    port_a_d = NONE;
                    port_b_d = NONE;
                    state_d  = StScan;
                end else if (a_lost || b_lost) begin
                    if (a_lost) port_a_d = NONE;
                    if (b_lost) port_b_d = NONE;
                    state_d = StScan;
                end else if (|(present_q & ~assigned) &&
                             (port_a_q == NONE || port_b_q == NONE)) begin
                    state_d = StScan;
                end
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StScan;
            idx_q    <= 2'd0;
            port_a_q <= NONE;
            port_b_q <= NONE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            port_a_q <= port_a_d;
            port_b_q <= port_b_d;
        end
    end

    // Free-running; autofire_en only gates its effect on the triggers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt_q   <= '0;
            af_phase_q <= 1'b0;
        end else if (af_cnt_q == AF_LAST) begin
            af_cnt_q   <= '0;
            af_phase_q <= ~af_phase_q;
        end else begin
            af_cnt_q <= af_cnt_q + 24'd1;
        end
    end

    function automatic logic [5:0] map_port(input logic [2:0] sel, input logic [63:0] keys,
                                            input logic af);
        logic [7:0] k;
        logic [5:0] w;
        k = keys[{sel[1:0], 4'b0000} +: 8];
        w = {k[5] | (k[7] & af), k[4] | (k[6] & af),
             k[3] & ~k[2], k[2] & ~k[3], k[1] & ~k[0], k[0] & ~k[1]};
        return sel[2] ? 6'h3F : ~w;
    endfunction

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            joy_a_q <= 6'h3F;
            joy_b_q <= 6'h3F;
        end else begin
            joy_a_q <= map_port(port_a_q, slot_keys, autofire_en & af_phase_q);
            joy_b_q <= map_port(port_b_q, slot_keys, autofire_en & af_phase_q);
        end
    end

    assign msx_joy_a   = joy_a_q;
    assign msx_joy_b   = joy_b_q;
    assign port_slot_a = port_a_q;
    assign port_slot_b = port_b_q;
    assign locked      = (state_q == StLock);

endmodule
